y_mat_addr_packer: RTL

Sequential packer that builds the Y-matrix row-address table consumed by the Y-matrix address-extraction logic. It accepts a stream of 11-bit row addresses over a valid/ready handshake and packs 16 entries into each 256-bit memory word. It issues full words to the Y-matrix memory over a write/acknowledge interface, and pads plus writes a partial final word on flush. It sits between the sparse-matrix setup logic and the Y-matrix memory write port.

---
 rtl/y_mat_addr_packer_if.sv | 29 ++
 rtl/y_mat_addr_packer.sv | 107 ++++++++++
 2 files changed

// File: rtl/y_mat_addr_packer_if.sv
// Handshake bundle between the sparse-matrix setup logic, the Y-matrix row-address
// packer and the Y-matrix memory write port.
interface y_mat_addr_packer_if #(
  parameter int ADDR_W = 16
);
  logic              pyma_start;
  logic [ADDR_W-1:0] pyma_base_addr;
  logic              pyma_in_valid;
  logic [10:0]       pyma_in_addr;
  logic              pyma_in_ready;
  logic              pyma_flush;
  logic              pyma_wr_en;
  logic [ADDR_W-1:0] pyma_wr_addr;
  logic [255:0]      pyma_wr_data;
  logic              pyma_wr_ack;
  logic              pyma_busy;
  logic              pyma_done;

  // master drives the packer (producer + memory side), slave is the packer itself
  modport master (
    output pyma_start, pyma_base_addr, pyma_in_valid, pyma_in_addr, pyma_flush, pyma_wr_ack,
    input  pyma_in_ready, pyma_wr_en, pyma_wr_addr, pyma_wr_data, pyma_busy, pyma_done
  );

  modport slave (
    input  pyma_start, pyma_base_addr, pyma_in_valid, pyma_in_addr, pyma_flush, pyma_wr_ack,
    output pyma_in_ready, pyma_wr_en, pyma_wr_addr, pyma_wr_data, pyma_busy, pyma_done
  );
endinterface

// File: rtl/y_mat_addr_packer.sv
// Packs 11-bit row addresses, 16 per 256-bit word (slot 0 in the MSBs), and writes
// each word to the Y-matrix memory; a flush pads and writes the partial last word.
module y_mat_addr_packer #(
  parameter int ADDR_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  y_mat_addr_packer_if.slave bus
);

  localparam int SLOTS   = 16;
  localparam int SLOT_W  = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]                    state;
  logic [SLOTS-1:0][SLOT_W-1:0]  word_q;
  logic [3:0]                    slot_q;
  logic [ADDR_W-1:0]             addr_q;
  logic                          last_q;
  logic                          flush_pend_q;
  logic                          done_q;

  logic accept;
  logic flush_now;

  assign accept    = (state == S_FILL) && bus.pyma_in_valid;
  assign flush_now = bus.pyma_flush | flush_pend_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      word_q       <= '0;
      slot_q       <= '0;
      addr_q       <= '0;
      last_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.pyma_start) begin
            state        <= S_FILL;
            word_q       <= '0;
            slot_q       <= '0;
            last_q       <= 1'b0;
            flush_pend_q <= 1'b0;
            addr_q       <= bus.pyma_base_addr;
          end
        end
        S_FILL: begin
          if (accept) begin
            // packed index 15-slot puts slot 0 in bits [255:240]
            word_q[~slot_q] <= {5'b0, bus.pyma_in_addr};
            slot_q          <= slot_q + 4'd1;
            if ((slot_q == 4'hF) || flush_now) begin
              state  <= S_WRITE;
              last_q <= flush_now;
            end
          end else if (flush_now) begin
            if (slot_q != 4'd0) begin
              state  <= S_WRITE;
              last_q <= 1'b1;
            end else begin
              state        <= S_IDLE;
              done_q       <= 1'b1;
              flush_pend_q <= 1'b0;
            end
          end
        end
        S_WRITE: begin
          if (bus.pyma_flush)
            flush_pend_q <= 1'b1;
          if (bus.pyma_wr_ack) begin
            addr_q <= addr_q + ADDR_W'(1);
            word_q <= '0;
            slot_q <= '0;
            if (last_q) begin
              state        <= S_IDLE;
              done_q       <= 1'b1;
              flush_pend_q <= 1'b0;
            end else begin
              state <= S_FILL;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.pyma_in_ready = (state == S_FILL);
  assign bus.pyma_wr_en    = (state == S_WRITE);
  assign bus.pyma_busy     = (state != S_IDLE);
  assign bus.pyma_done     = done_q;
  assign bus.pyma_wr_addr  = addr_q;
  assign bus.pyma_wr_data  = word_q;

  a_done_idle: assert property (@(posedge clock) disable iff (reset)
    bus.pyma_done |-> !bus.pyma_busy);
  a_wr_no_rdy: assert property (@(posedge clock) disable iff (reset)
    bus.pyma_wr_en |-> !bus.pyma_in_ready);

endmodule
